// File: rtl/fosfor_nibble_bus_responder_pkg.sv
// Purpose: shared encodings for the nibble host bus responder (bus phases, command codes, status bits).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fosfor_bus_pkg;

    // Bus phase carried on Address_b
    typedef enum logic [1:0] {
        ADDR_IDLE = 2'b00,
        ADDR_CMD  = 2'b01,
        ADDR_LOW  = 2'b10,
        ADDR_HIGH = 2'b11
    } addr_phase_e;

    // One-hot command codes carried on DataIn_b during the CMD phase
    localparam logic [3:0] CMD_LATCH_ADDRESS = 4'b0001;
    localparam logic [3:0] CMD_READ          = 4'b0010;
    localparam logic [3:0] CMD_WRITE         = 4'b0100;
    localparam logic [3:0] CMD_START         = 4'b1000;

    // Bit positions inside the status byte
    localparam int STATUS_READY      = 0;
    localparam int STATUS_READ_VALID = 1;
    localparam int STATUS_CMD_ERR    = 2;

    function automatic logic [7:0] make_status(input logic cmd_err,
                                               input logic read_valid,
                                               input logic ready);
        logic [7:0] s;
        s                    = 8'h00;
        s[STATUS_CMD_ERR]    = cmd_err;
        s[STATUS_READ_VALID] = read_valid;
        s[STATUS_READY]      = ready;
        return s;
    endfunction

endpackage

// File: rtl/fosfor_nibble_bus_responder.sv
// Purpose: chip-side responder for the 4-bit nibble host bus; assembles bytes, decodes one-hot commands, drives a byte register port.
// Latency: strobes 1 cycle after the first CMD edge; read byte lands in ReadBuf READ_LATENCY edges after the READ command edge.
// Backpressure: none on the bus; START is refused (CmdErr set) while Ready_i is low, a newer READ discards an in-flight one.
//
// Ports:
//   Clk_k, Reset_r          clock (rising edge), asynchronous active-high reset
//   Address_b, DataIn_b     host bus phase and nibble
//   DataOut_b               registered bus return: ReadBuf in LOW phase, status byte otherwise
//   RegAddr_o, RegWrData_o  latched register address, assembled data byte
//   RegWr_o, RegRd_o        1-cycle register strobes
//   RegRdData_i             register read data, sampled READ_LATENCY edges after the READ command edge
//   Start_o, Ready_i        1-cycle core start pulse, core idle / result valid
module fosfor_nibble_bus_responder
    import fosfor_bus_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic       Clk_k,
    input  logic       Reset_r,
    input  logic [1:0] Address_b,
    input  logic [3:0] DataIn_b,
    output logic [7:0] DataOut_b,
    output logic [7:0] RegAddr_o,
    output logic [7:0] RegWrData_o,
    output logic       RegWr_o,
    output logic       RegRd_o,
    input  logic [7:0] RegRdData_i,
    output logic       Start_o,
    input  logic       Ready_i
);

    addr_phase_e                 phase;
    addr_phase_e                 prev_phase;
    logic [7:0]                  data_buf;
    logic [7:0]                  read_buf;
    logic                        read_valid;
    logic                        cmd_err;
    logic [READ_LATENCY-1:0]     rd_pipe;
    logic                        cmd_first;
    logic                        read_issue;
    logic                        read_done;
    logic [7:0]                  status;

    assign phase       = addr_phase_e'(Address_b);
    assign RegWrData_o = data_buf;
    assign status      = make_status(cmd_err, read_valid, Ready_i);

    // A command only executes on the edge where CMD is entered; a held CMD phase is inert.
    assign cmd_first  = (phase == ADDR_CMD) && (prev_phase != ADDR_CMD);
    assign read_issue = cmd_first && (DataIn_b == CMD_READ);
    // A READ issued on the same edge as an older completion supersedes it.
    assign read_done  = rd_pipe[READ_LATENCY-1] && !read_issue;

    always_ff @(posedge Clk_k or posedge Reset_r) begin
        if (Reset_r) begin
            prev_phase <= ADDR_IDLE;
            data_buf   <= 8'h00;
            read_buf   <= 8'h00;
            read_valid <= 1'b0;
            cmd_err    <= 1'b0;
            rd_pipe    <= '0;
            RegAddr_o  <= 8'h00;
            RegWr_o    <= 1'b0;
            RegRd_o    <= 1'b0;
            Start_o    <= 1'b0;
            DataOut_b  <= 8'h00;
        end else begin
            RegWr_o    <= 1'b0;
            RegRd_o    <= 1'b0;
            Start_o    <= 1'b0;
            prev_phase <= phase;
            rd_pipe    <= rd_pipe << 1;

            // Bus return reflects ReadBuf/status as they stood before this edge.
            DataOut_b  <= (phase == ADDR_LOW) ? read_buf : status;

            if (read_done) begin
                read_buf   <= RegRdData_i;
                read_valid <= 1'b1;
            end

            case (phase)
                ADDR_LOW:  data_buf[3:0] <= DataIn_b;
                ADDR_HIGH: data_buf[7:4] <= DataIn_b;
                default:   ;
            endcase

            if (cmd_first) begin
                case (DataIn_b)
                    CMD_LATCH_ADDRESS: begin
                        RegAddr_o <= data_buf;
                        cmd_err   <= 1'b0;
                    end
                    CMD_READ: begin
                        RegRd_o    <= 1'b1;
                        read_valid <= 1'b0;
                        cmd_err    <= 1'b0;
                        // Restart the pipe so only this newest read completes.
                        rd_pipe    <= READ_LATENCY'(1);
                    end
                    CMD_WRITE: begin
                        RegWr_o <= 1'b1;
                        cmd_err <= 1'b0;
                    end
                    CMD_START: begin
                        if (Ready_i) begin
                            Start_o <= 1'b1;
                            cmd_err <= 1'b0;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                    default: cmd_err <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fosfor_nibble_bus_responder.sv
// Purpose: directed, table-driven check of the nibble bus responder (latency 1) plus a latency-3 instance.
// Latency: inputs change 1 time unit after a rising edge, outputs sampled 1 time unit after the next.
// Backpressure: n/a.
module tb_fosfor_nibble_bus_responder;
    import fosfor_bus_pkg::*;

    typedef struct {
        logic [1:0] a;
        logic [3:0] d;
        logic       rdy;
        logic [7:0] rdd;
        logic [7:0] dout;
        logic [7:0] raddr;
        logic [7:0] wdat;
        logic       wr;
        logic       rd;
        logic       st;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] addr,  addr3;
    logic [3:0] din,   din3;
    logic [7:0] dout,  dout3;
    logic [7:0] raddr, raddr3;
    logic [7:0] wdat,  wdat3;
    logic       wr,    wr3;
    logic       rd,    rd3;
    logic [7:0] rdd,   rdd3;
    logic       st,    st3;
    logic       rdy,   rdy3;

    int checks = 0;
    int errors = 0;
    vec_t vecs[37];

    always #5 clk = ~clk;

    fosfor_nibble_bus_responder #(.READ_LATENCY(1)) u_dut (
        .Clk_k(clk), .Reset_r(rst), .Address_b(addr), .DataIn_b(din), .DataOut_b(dout),
        .RegAddr_o(raddr), .RegWrData_o(wdat), .RegWr_o(wr), .RegRd_o(rd),
        .RegRdData_i(rdd), .Start_o(st), .Ready_i(rdy)
    );

    fosfor_nibble_bus_responder #(.READ_LATENCY(3)) u_dut3 (
        .Clk_k(clk), .Reset_r(rst), .Address_b(addr3), .DataIn_b(din3), .DataOut_b(dout3),
        .RegAddr_o(raddr3), .RegWrData_o(wdat3), .RegWr_o(wr3), .RegRd_o(rd3),
        .RegRdData_i(rdd3), .Start_o(st3), .Ready_i(rdy3)
    );

    function automatic vec_t mk(input logic [1:0] a, input logic [3:0] d, input logic r,
                                input logic [7:0] rdat, input logic [7:0] eo,
                                input logic [7:0] ea, input logic [7:0] ew,
                                input logic ewr, input logic erd, input logic est);
        vec_t v;
        v.a = a; v.d = d; v.rdy = r; v.rdd = rdat;
        v.dout = eo; v.raddr = ea; v.wdat = ew; v.wr = ewr; v.rd = erd; v.st = est;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the latency-3 instance; the strobes it must never raise are checked too.
    task automatic step3(input string name, input logic [1:0] a, input logic [3:0] d,
                         input logic [7:0] rdat, input logic [7:0] eo, input logic erd);
        addr3 = a; din3 = d; rdd3 = rdat;
        tick();
        chk({name, " dout3"}, dout3, eo);
        chk({name, " rd3"},   {7'b0, rd3}, {7'b0, erd});
        chk({name, " wr3/st3"}, {6'b0, wr3, st3}, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // a, d, rdy, rdd | dout, RegAddr, RegWrData, wr, rd, start  (values after the edge)
        vecs[0]  = mk(ADDR_IDLE, 4'h0, 1, 8'h00, 8'h01, 8'h00, 8'h00, 0, 0, 0);
        vecs[1]  = mk(ADDR_LOW,  4'h5, 1, 8'h00, 8'h00, 8'h00, 8'h05, 0, 0, 0);
        vecs[2]  = mk(ADDR_HIGH, 4'hA, 1, 8'h00, 8'h01, 8'h00, 8'hA5, 0, 0, 0);
        vecs[3]  = mk(ADDR_CMD,  4'h1, 1, 8'h00, 8'h01, 8'hA5, 8'hA5, 0, 0, 0);
        vecs[4]  = mk(ADDR_IDLE, 4'h0, 1, 8'h00, 8'h01, 8'hA5, 8'hA5, 0, 0, 0);
        vecs[5]  = mk(ADDR_LOW,  4'h8, 1, 8'h00, 8'h00, 8'hA5, 8'hA8, 0, 0, 0);
        vecs[6]  = mk(ADDR_HIGH, 4'h0, 1, 8'h00, 8'h01, 8'hA5, 8'h08, 0, 0, 0);
        vecs[7]  = mk(ADDR_CMD,  4'h1, 1, 8'h00, 8'h01, 8'h08, 8'h08, 0, 0, 0);
        vecs[8]  = mk(ADDR_LOW,  4'h5, 1, 8'h00, 8'h00, 8'h08, 8'h05, 0, 0, 0);
        vecs[9]  = mk(ADDR_HIGH, 4'hA, 1, 8'h00, 8'h01, 8'h08, 8'hA5, 0, 0, 0);
        vecs[10] = mk(ADDR_CMD,  4'h4, 1, 8'h00, 8'h01, 8'h08, 8'hA5, 1, 0, 0);
        vecs[11] = mk(ADDR_CMD,  4'h4, 1, 8'h00, 8'h01, 8'h08, 8'hA5, 0, 0, 0);
        vecs[12] = mk(ADDR_CMD,  4'h4, 1, 8'h00, 8'h01, 8'h08, 8'hA5, 0, 0, 0);
        vecs[13] = mk(ADDR_IDLE, 4'h0, 1, 8'h00, 8'h01, 8'h08, 8'hA5, 0, 0, 0);
        vecs[14] = mk(ADDR_CMD,  4'h8, 1, 8'h00, 8'h01, 8'h08, 8'hA5, 0, 0, 1);
        vecs[15] = mk(ADDR_IDLE, 4'h0, 0, 8'h00, 8'h00, 8'h08, 8'hA5, 0, 0, 0);
        vecs[16] = mk(ADDR_CMD,  4'h8, 0, 8'h00, 8'h00, 8'h08, 8'hA5, 0, 0, 0);
        vecs[17] = mk(ADDR_IDLE, 4'h0, 0, 8'h00, 8'h04, 8'h08, 8'hA5, 0, 0, 0);
        vecs[18] = mk(ADDR_CMD,  4'h1, 0, 8'h00, 8'h04, 8'hA5, 8'hA5, 0, 0, 0);
        vecs[19] = mk(ADDR_IDLE, 4'h0, 0, 8'h00, 8'h00, 8'hA5, 8'hA5, 0, 0, 0);
        vecs[20] = mk(ADDR_CMD,  4'h3, 1, 8'h00, 8'h01, 8'hA5, 8'hA5, 0, 0, 0);
        vecs[21] = mk(ADDR_IDLE, 4'h0, 1, 8'h00, 8'h05, 8'hA5, 8'hA5, 0, 0, 0);
        vecs[22] = mk(ADDR_CMD,  4'h1, 1, 8'h00, 8'h05, 8'hA5, 8'hA5, 0, 0, 0);
        vecs[23] = mk(ADDR_IDLE, 4'h0, 1, 8'h00, 8'h01, 8'hA5, 8'hA5, 0, 0, 0);
        vecs[24] = mk(ADDR_CMD,  4'h0, 1, 8'h00, 8'h01, 8'hA5, 8'hA5, 0, 0, 0);
        vecs[25] = mk(ADDR_IDLE, 4'h0, 1, 8'h00, 8'h05, 8'hA5, 8'hA5, 0, 0, 0);
        vecs[26] = mk(ADDR_CMD,  4'h2, 1, 8'hA5, 8'h05, 8'hA5, 8'hA5, 0, 1, 0);
        vecs[27] = mk(ADDR_IDLE, 4'h0, 1, 8'hA5, 8'h01, 8'hA5, 8'hA5, 0, 0, 0);
        vecs[28] = mk(ADDR_LOW,  4'h3, 1, 8'hA5, 8'hA5, 8'hA5, 8'hA3, 0, 0, 0);
        vecs[29] = mk(ADDR_IDLE, 4'h0, 1, 8'hA5, 8'h03, 8'hA5, 8'hA3, 0, 0, 0);
        vecs[30] = mk(ADDR_CMD,  4'h2, 1, 8'hA5, 8'h03, 8'hA5, 8'hA3, 0, 1, 0);
        vecs[31] = mk(ADDR_LOW,  4'h5, 1, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 0, 0, 0);
        vecs[32] = mk(ADDR_IDLE, 4'h0, 1, 8'hA5, 8'h03, 8'hA5, 8'hA5, 0, 0, 0);
        vecs[33] = mk(ADDR_CMD,  4'h2, 1, 8'h3C, 8'h03, 8'hA5, 8'hA5, 0, 1, 0);
        vecs[34] = mk(ADDR_LOW,  4'hC, 1, 8'h3C, 8'hA5, 8'hA5, 8'hAC, 0, 0, 0);
        vecs[35] = mk(ADDR_LOW,  4'hC, 1, 8'h3C, 8'h3C, 8'hA5, 8'hAC, 0, 0, 0);
        vecs[36] = mk(ADDR_IDLE, 4'h0, 1, 8'h3C, 8'h03, 8'hA5, 8'hAC, 0, 0, 0);

        rst = 1'b1;
        addr = ADDR_IDLE; din = 4'h0; rdd = 8'h00; rdy = 1'b1;
        addr3 = ADDR_IDLE; din3 = 4'h0; rdd3 = 8'h00; rdy3 = 1'b1;
        tick();
        tick();
        chk("reset dout", dout, 8'h00);
        chk("reset raddr", raddr, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 37; i++) begin
            addr = vecs[i].a; din = vecs[i].d; rdy = vecs[i].rdy; rdd = vecs[i].rdd;
            tick();
            chk($sformatf("v%0d dout", i),  dout,  vecs[i].dout);
            chk($sformatf("v%0d raddr", i), raddr, vecs[i].raddr);
            chk($sformatf("v%0d wdat", i),  wdat,  vecs[i].wdat);
            chk($sformatf("v%0d strobes", i), {5'b0, wr, rd, st},
                {5'b0, vecs[i].wr, vecs[i].rd, vecs[i].st});
        end
        addr = ADDR_IDLE; din = 4'h0;

        // Latency-3 read: valid rises three edges after the READ edge.
        step3("l3 cmd",  ADDR_CMD,  4'h2, 8'h11, 8'h01, 1);
        step3("l3 i1",   ADDR_IDLE, 4'h0, 8'h22, 8'h01, 0);
        step3("l3 i2",   ADDR_IDLE, 4'h0, 8'h33, 8'h01, 0);
        step3("l3 i3",   ADDR_IDLE, 4'h0, 8'h44, 8'h01, 0);
        step3("l3 i4",   ADDR_IDLE, 4'h0, 8'h00, 8'h03, 0);
        step3("l3 low",  ADDR_LOW,  4'h0, 8'h00, 8'h44, 0);
        // Back-to-back READs: the first must never complete.
        step3("b2b c1",  ADDR_CMD,  4'h2, 8'h55, 8'h03, 1);
        step3("b2b i1",  ADDR_IDLE, 4'h0, 8'h66, 8'h01, 0);
        step3("b2b c2",  ADDR_CMD,  4'h2, 8'h77, 8'h01, 1);
        step3("b2b i2",  ADDR_IDLE, 4'h0, 8'h88, 8'h01, 0);
        step3("b2b i3",  ADDR_IDLE, 4'h0, 8'h99, 8'h01, 0);
        step3("b2b i4",  ADDR_IDLE, 4'h0, 8'hAA, 8'h01, 0);
        step3("b2b i5",  ADDR_IDLE, 4'h0, 8'h00, 8'h03, 0);
        step3("b2b low", ADDR_LOW,  4'h0, 8'h00, 8'hAA, 0);

        // Reset mid-stream with a latency-3 read in flight.
        addr = ADDR_LOW; din = 4'h7;
        step3("mid cmd", ADDR_CMD, 4'h2, 8'hEE, 8'h03, 1);
        chk("mid wdat", wdat, 8'hA7);
        addr = ADDR_IDLE; din = 4'h0; addr3 = ADDR_IDLE; din3 = 4'h0;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk($sformatf("rst%0d dout", c), dout, 8'h00);
            chk($sformatf("rst%0d raddr", c), raddr, 8'h00);
            chk($sformatf("rst%0d wdat", c), wdat, 8'h00);
            chk($sformatf("rst%0d strobes", c), {5'b0, wr, rd, st}, 8'h00);
            chk($sformatf("rst%0d dout3", c), dout3, 8'h00);
            chk($sformatf("rst%0d raddr3/wdat3", c), raddr3 | wdat3, 8'h00);
        end
        rst = 1'b0;
        tick();
        chk("post-rst dout", dout, 8'h01);
        chk("post-rst dout3", dout3, 8'h01);
        for (int c = 0; c < 4; c++)
            step3($sformatf("discard%0d", c), ADDR_IDLE, 4'h0, 8'hEE, 8'h01, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
